// File: rtl/rsa_pkg.sv
// Shared RSA toy-cipher constants, decoder state encoding and the tgbase
// 6-bit field to printable ASCII mapping used by both encoder and decoder.
package rsa_pkg;

    localparam int RSA_N      = 10403;
    localparam int RSA_E      = 71;
    localparam int RSA_D      = 431;
    localparam int RSA_D_BITS = 9;
    localparam int RSA_MM_CYC = 15;

    localparam int CIPHER_W = 14;
    localparam int ASCII_W  = 7;
    localparam int FIELD_W  = 6;
    localparam int ACC_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_SQR,
        ST_CHK,
        ST_OUT_HI,
        ST_OUT_LO
    } state_e;

    // Four contiguous runs: " !", "0-9", "A-Z", "a-z".
    function automatic logic [ASCII_W-1:0] tgbase_to_ascii(input logic [FIELD_W-1:0] t);
        logic [ASCII_W-1:0] w;
        w = ASCII_W'(t);
        if (t < 6'd2) begin
            return w + 7'd32;
        end else if (t < 6'd12) begin
            return w + 7'd46;
        end else if (t < 6'd38) begin
            return w + 7'd53;
        end else begin
            return w + 7'd59;
        end
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Fixed-latency modular multiplier: interleaved shift-add over a (MSB first)
// with up to two subtractions of N per step; done exactly MM_CYC cycles after start.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int N      = RSA_N,
    parameter int MM_CYC = RSA_MM_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [CIPHER_W-1:0] a_i,
    input  logic [CIPHER_W-1:0] b_i,
    output logic                done_o,
    output logic [CIPHER_W-1:0] result_o
);

    localparam int CNT_W = $clog2(MM_CYC + 1);
    localparam logic [ACC_W-1:0] N_ACC = ACC_W'(N);

    logic [CIPHER_W-1:0] a_q, a_d;
    logic [CIPHER_W-1:0] b_q, b_d;
    logic [CIPHER_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;

    logic [ACC_W-1:0] sum1, sum2, sum3;

    // Cycles 1..CIPHER_W after start consume one bit of a; the rest is idle padding.
    always_comb begin
        sum1 = ACC_W'({acc_q, 1'b0}) + (a_q[CIPHER_W-1] ? ACC_W'(b_q) : '0);
        sum2 = (sum1 >= N_ACC) ? sum1 - N_ACC : sum1;
        sum3 = (sum2 >= N_ACC) ? sum2 - N_ACC : sum2;

        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (start_i) begin
            a_d    = a_i;
            b_d    = b_i;
            acc_d  = '0;
            cnt_d  = CNT_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q <= CNT_W'(CIPHER_W)) begin
                acc_d = sum3[CIPHER_W-1:0];
                a_d   = a_q << 1;
            end
            if (cnt_q == CNT_W'(MM_CYC)) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o   = busy_q && (cnt_q == CNT_W'(MM_CYC));
    assign result_o = acc_q;

endmodule

// File: rtl/rsa_decoder.sv
// RSA ciphertext-to-ASCII decoder: left-to-right-free square-and-multiply with
// constant-time multiplies, plaintext field check, then two handshaked characters.
module rsa_decoder
    import rsa_pkg::*;
#(
    parameter int N      = RSA_N,
    parameter int D      = RSA_D,
    parameter int D_BITS = RSA_D_BITS,
    parameter int MM_CYC = RSA_MM_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cipher_valid,
    input  logic [CIPHER_W-1:0] cipher_data,
    output logic                cipher_ready,
    output logic                ascii_valid,
    output logic [ASCII_W-1:0]  ascii_data,
    input  logic                ascii_ready,
    output logic                err
);

    localparam int IDX_W = (D_BITS > 1) ? $clog2(D_BITS) : 1;
    localparam logic [D_BITS-1:0]   D_VEC = D_BITS'(D);
    localparam logic [CIPHER_W-1:0] N_W   = CIPHER_W'(N);

    state_e              state_q, state_d;
    logic [CIPHER_W-1:0] base_q, base_d;
    logic [CIPHER_W-1:0] result_q, result_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                err_q, err_d;

    logic                mm_start;
    logic [CIPHER_W-1:0] mm_a, mm_b;
    logic                mm_done;
    logic [CIPHER_W-1:0] mm_result;

    rsa_modmul #(
        .N      (N),
        .MM_CYC (MM_CYC)
    ) u_modmul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mm_start),
        .a_i      (mm_a),
        .b_i      (mm_b),
        .done_o   (mm_done),
        .result_o (mm_result)
    );

    // The first multiply (1 * cipher) is launched in the transfer cycle itself so
    // LOAD's range check overlaps it; each done immediately launches the next op.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        result_d = result_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        mm_start = 1'b0;
        mm_a     = result_q;
        mm_b     = base_q;

        case (state_q)
            ST_IDLE: begin
                if (cipher_valid) begin
                    base_d   = cipher_data;
                    result_d = CIPHER_W'(1);
                    idx_d    = '0;
                    mm_start = 1'b1;
                    mm_a     = CIPHER_W'(1);
                    mm_b     = cipher_data;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (base_q >= N_W) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mm_done) begin
                    if (D_VEC[idx_q]) begin
                        result_d = mm_result;
                    end
                    if (idx_q == IDX_W'(D_BITS - 1)) begin
                        state_d = ST_CHK;
                    end else begin
                        mm_start = 1'b1;
                        mm_a     = base_q;
                        mm_b     = base_q;
                        state_d  = ST_SQR;
                    end
                end
            end
            ST_SQR: begin
                if (mm_done) begin
                    base_d   = mm_result;
                    idx_d    = idx_q + 1'b1;
                    mm_start = 1'b1;
                    mm_a     = result_q;
                    mm_b     = mm_result;
                    state_d  = ST_MUL;
                end
            end
            ST_CHK: begin
                if (result_q[13] || result_q[6]) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT_HI;
                end
            end
            ST_OUT_HI: begin
                if (ascii_ready) begin
                    state_d = ST_OUT_LO;
                end
            end
            ST_OUT_LO: begin
                if (ascii_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        ascii_data = '0;
        if (state_q == ST_OUT_HI) begin
            ascii_data = tgbase_to_ascii(result_q[12:7]);
        end else if (state_q == ST_OUT_LO) begin
            ascii_data = tgbase_to_ascii(result_q[5:0]);
        end
    end

    assign cipher_ready = (state_q == ST_IDLE);
    assign ascii_valid  = (state_q == ST_OUT_HI) || (state_q == ST_OUT_LO);
    assign err          = err_q;

endmodule

// File: tb/tb_rsa_decoder.sv
// Self-checking bench for rsa_decoder: directed cases, random ciphertexts and
// encrypt/decrypt round trips against a plain-arithmetic RSA reference model.
module tb_rsa_decoder;

    localparam int MOD_N   = 10403;
    localparam int EXP_E   = 71;
    localparam int EXP_D   = 431;
    localparam int LATENCY = 257;

    logic        clk;
    logic        rst;
    logic        cipher_valid;
    logic [13:0] cipher_data;
    logic        cipher_ready;
    logic        ascii_valid;
    logic [6:0]  ascii_data;
    logic        ascii_ready;
    logic        err;

    int checks;
    int errors;

    string alphabet;

    rsa_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .cipher_valid (cipher_valid),
        .cipher_data  (cipher_data),
        .cipher_ready (cipher_ready),
        .ascii_valid  (ascii_valid),
        .ascii_data   (ascii_data),
        .ascii_ready  (ascii_ready),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int powMod(input int b, input int e, input int m);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) begin
            r = (r * longint'(b)) % longint'(m);
        end
        return int'(r);
    endfunction

    function automatic int charOf(input int t);
        return int'(alphabet[t]);
    endfunction

    // Offer one word, then follow it through to err or two characters.
    task automatic applyStimulus(input int word, input int stall, input int expErr,
                                 input int expN, input int expHi, input int expLo);
        int n;
        int waitCnt;
        waitCnt = 0;
        while (!cipher_ready && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("ready_before_word", int'(cipher_ready), 1);
        cipher_valid = 1'b1;
        cipher_data  = 14'(word);
        @(posedge clk); #1;
        cipher_valid = 1'b0;
        cipher_data  = '0;
        n = 1;
        while (!ascii_valid && !err && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", n, expN);
        checkOutput("err_flag", int'(err), expErr);
        if (expErr == 0) begin
            checkOutput("hi_valid", int'(ascii_valid), 1);
            checkOutput("hi_char", int'(ascii_data), expHi);
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                checkOutput("hold_valid", int'(ascii_valid), 1);
                checkOutput("hold_char", int'(ascii_data), expHi);
            end
            ascii_ready = 1'b1;
            @(posedge clk); #1;
            checkOutput("lo_valid", int'(ascii_valid), 1);
            checkOutput("lo_char", int'(ascii_data), expLo);
            @(posedge clk); #1;
            ascii_ready = 1'b0;
            checkOutput("end_valid", int'(ascii_valid), 0);
            checkOutput("end_ready", int'(cipher_ready), 1);
        end else begin
            checkOutput("err_no_valid", int'(ascii_valid), 0);
            @(posedge clk); #1;
            checkOutput("err_one_cycle", int'(err), 0);
            checkOutput("err_ready", int'(cipher_ready), 1);
            checkOutput("err_still_no_valid", int'(ascii_valid), 0);
        end
    endtask

    task automatic decodeModel(input int word, input int stall);
        int p;
        if (word >= MOD_N) begin
            applyStimulus(word, stall, 1, 2, 0, 0);
        end else begin
            p = powMod(word, EXP_D, MOD_N);
            if ((p & 8192) != 0 || (p & 64) != 0) begin
                applyStimulus(word, stall, 1, LATENCY, 0, 0);
            end else begin
                applyStimulus(word, stall, 0, LATENCY, charOf((p / 128) % 64), charOf(p % 64));
            end
        end
    endtask

    task automatic roundTrip(input int hi, input int lo, input int stall);
        int c;
        c = powMod(hi * 128 + lo, EXP_E, MOD_N);
        applyStimulus(c, stall, 0, LATENCY, charOf(hi), charOf(lo));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int seen;
        alphabet     = " !0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        cipher_valid = 1'b0;
        cipher_data  = '0;
        ascii_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", int'(cipher_ready), 1);
        checkOutput("rst_valid", int'(ascii_valid), 0);
        checkOutput("rst_data", int'(ascii_data), 0);
        checkOutput("rst_err", int'(err), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_ready", int'(cipher_ready), 1);

        applyStimulus(345, 0, 0, LATENCY, 72, 101);
        applyStimulus(1, 0, 0, LATENCY, 32, 33);
        applyStimulus(0, 0, 0, LATENCY, 32, 32);
        applyStimulus(10403, 0, 1, 2, 0, 0);
        applyStimulus(16383, 0, 1, 2, 0, 0);
        applyStimulus(345, 20, 0, LATENCY, 72, 101);

        // Reset in the middle of an exponentiation must discard the word.
        while (!cipher_ready) begin
            @(posedge clk); #1;
        end
        cipher_valid = 1'b1;
        cipher_data  = 14'd345;
        @(posedge clk); #1;
        cipher_valid = 1'b0;
        cipher_data  = '0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_ready", int'(cipher_ready), 1);
        checkOutput("midrst_err", int'(err), 0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (ascii_valid || err) seen++;
            @(posedge clk); #1;
        end
        checkOutput("midrst_no_output", seen, 0);
        applyStimulus(1, 0, 0, LATENCY, 32, 33);

        roundTrip(0, 0, 0);
        roundTrip(63, 63, 1);
        roundTrip(1, 2, 0);
        roundTrip(11, 12, 2);
        roundTrip(37, 38, 0);

        for (int i = 0; i < 25; i++) begin
            roundTrip(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 20; i++) begin
            decodeModel(int'($urandom_range(0, 16383)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_decoder.md
RSA_DECODER -- requirements
Module: rsa_decoder

Interface
REQ-001 Parameter N, default 10403 (101*103), RSA modulus.
REQ-002 Parameter D, default 431, private exponent; D_BITS, default 9, exponent bits processed.
REQ-003 Parameter MM_CYC, default 15, fixed modular-multiply latency in cycles.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cipher_valid  in  1  ciphertext word offered.
REQ-007 cipher_data  in  14  ciphertext word.
REQ-008 cipher_ready  out  1  decoder can accept a word.
REQ-009 ascii_valid  out  1  character available.
REQ-010 ascii_data  out  7  decoded ASCII character.
REQ-011 ascii_ready  in  1  sink accepts character.
REQ-012 err  out  1  one-cycle pulse on rejected or malformed word.

Function
REQ-013 Word transfer occurs on a cycle with cipher_valid and cipher_ready both high; character transfer occurs on a cycle with ascii_valid and ascii_ready both high.
REQ-014 cipher_ready SHALL be high only in IDLE; exactly one word is in flight.
REQ-015 States: IDLE, LOAD, MUL, SQR, CHK, OUT_HI, OUT_LO; IDLE->LOAD on transfer.
REQ-016 LOAD: base = cipher_data, result = 1, bit index = 0; if cipher_data >= N, pulse err next cycle and return to IDLE with no characters emitted.
REQ-017 MUL: always issue result*base mod N; commit to result only when D[index] = 1 (fixed latency independent of D).
REQ-018 SQR: issue base*base mod N for index 0..D_BITS-2; after the MUL of index D_BITS-1, go to CHK instead.
REQ-019 Exponentiation issues exactly 2*D_BITS-1 modular multiplies; each takes exactly MM_CYC cycles.
REQ-020 ascii_valid SHALL rise exactly 2 + (2*D_BITS-1)*MM_CYC cycles (257 at defaults) after the word-transfer cycle.
REQ-021 CHK: plaintext P, 14 bits; P[13] or P[6] set -> err pulse, no output, go to IDLE; else go to OUT_HI.
REQ-022 Field hi = P[12:7], lo = P[5:0]; OUT_HI presents char(hi), OUT_LO presents char(lo).
REQ-023 Mapping char(t): t 0-1 -> t+32; 2-11 -> t+46; 12-37 -> t+53; 38-63 -> t+59.
REQ-024 ascii_data and ascii_valid SHALL hold stable while ascii_ready is low; OUT_HI->OUT_LO and OUT_LO->IDLE only on transfer.
REQ-025 ascii_valid may be high in the same cycle ascii_ready rises; zero-wait back-to-back transfer required (OUT_HI to OUT_LO in consecutive cycles).
REQ-026 Multiplier: operands and result 14 bits, result < N; intermediate accumulator 16 bits minimum, no truncation.

Reset
REQ-027 On rst: state IDLE, cipher_ready 1 in the following cycle, ascii_valid 0, ascii_data 0, err 0, internal registers 0, multiplier aborted.
REQ-028 rst asserted mid-exponentiation or mid-output discards the word; no partial character emitted after reset.

Structure
REQ-029 Package rsa_pkg holds N, E (71), D, D_BITS, widths, the state enum, and the tgbase-to-ASCII function shared with the encoder.
REQ-030 Sub-module rsa_modmul: start/done, interleaved shift-add, MSB-first over 14 bits of a, up to two conditional subtractions of N per cycle, done exactly MM_CYC cycles after start.

Verification
REQ-031 cipher 345 -> 'H' (72) then 'e' (101), ascii_valid at cycle +257, err 0.
REQ-032 cipher 1 -> ' ' (32) then '!' (33); cipher 0 -> ' ' ' ' (32, 32).
REQ-033 cipher 10403 -> err pulse one cycle, no ascii_valid, cipher_ready high again.
REQ-034 cipher 345 with ascii_ready low for 20 cycles -> ascii_data holds 72 stable, then 72, 101 in order.
REQ-035 rst asserted 100 cycles after accepting 345 -> no output, cipher_ready high in the cycle after rst deasserts, next word 1 decodes correctly.
REQ-036 Round trip: all 4096 valid tgbase pairs encrypted with E in the model -> decoder output equals the original character pair.
